alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Controller that shares the single 32-bit ALU between two requesters: requester 0 is the main execute datapath and requester 1 is the address/branch unit.
- Arbitrates requests round-robin, drives the ALU operand and select ports from registered copies, and waits extra cycles for MUL/DIV (multicycle paths).
- Returns the registered result and zero flag through a valid/ready response port tagged with the requester ID.

Parameters:
- DATA_W, 32, operand/result width.
- SEL_W, 3, ALU select width.
- MULDIV_WAIT, 2, EXEC cycles for SEL 5 (MUL) and 6 (DIV); minimum 1.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid / req1_valid  in  1  request pending.
- req0_ready / req1_ready  out  1  request accepted this cycle.
- req0_x, req0_y / req1_x, req1_y  in  DATA_W  operands.
- req0_sel / req1_sel  in  SEL_W  ALU op: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 SLT, 5 MUL, 6 DIV, 7 NOP.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer accepts result.
- rsp_id  out  1  requester index of the result.
- rsp_r  out  DATA_W  captured ALU result.
- rsp_z  out  1  captured ALU zero flag.
- alu_x, alu_y  out  DATA_W  ALU operands.
- alu_sel  out  SEL_W  ALU select.
- alu_r  in  DATA_W  ALU result.
- alu_z  in  1  ALU zero flag.
- busy  out  1  state is not IDLE.

Behaviour:
- Reset values: state IDLE, rr pointer = requester 0 has priority, alu_x = alu_y = 0, alu_sel = 7 (NOP), rsp_valid = 0, rsp_id = 0, rsp_r = 0, rsp_z = 0, wait counter = 0.
- Reset mid-operation aborts the in-flight op. No response is produced for it.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
- IDLE:
  - reqN_ready = grantN, combinational, asserted only in IDLE. At most one ready is high.
  - Transfer occurs when valid && ready. On transfer: latch x, y, sel and id into alu_x, alu_y, alu_sel and the id register.
  - Load the counter with MULDIV_WAIT-1 if sel is 5 or 6, else 0. Go to EXEC.
  - Arbitration: only one valid gets that requester. If both are valid, the pointer decides.
  - After every grant the pointer is set to favour the non-granted requester.
  - No valid: stay in IDLE, alu_sel held at 7.
- EXEC:
  - ALU ports are held stable.
  - When the counter is 0: capture alu_r -> rsp_r and alu_z -> rsp_z, set rsp_valid = 1, go to RESP.
  - Otherwise decrement the counter.
- RESP:
  - rsp_valid stays high and rsp_r, rsp_z, rsp_id stay stable until rsp_ready.
  - On rsp_valid && rsp_ready: clear rsp_valid, set alu_sel = 7, go to IDLE.
  - No new request is accepted in the same cycle.
- Latency, accept edge t to rsp_valid high:
  - t+1 for SEL 0-4 and 7.
  - t+MULDIV_WAIT for SEL 5 and 6.
  - Minimum issue interval is 3 cycles.
- Requester contract: hold valid, x, y and sel stable until ready. Dropping valid before ready is legal and cancels the request.
- Simultaneous events:
  - Requests arriving during EXEC or RESP wait. They are not lost, and ready stays low.
  - rsp_ready held constantly high gives single-cycle RESP.
- Width rules: no arithmetic in this block. Results are passed through unmodified. The counter is $clog2(MULDIV_WAIT)+1 bits.

Optional Feature:
- Macro: ALU_ARB_DIV0_TRAP_EN.
- Enabled:
  - Extra output port rsp_err (1 bit, reset 0).
  - On accepting sel == 6 with y == 0, skip EXEC and go directly to RESP.
  - rsp_r = all ones, rsp_z = 0, rsp_err = 1. The ALU is never driven with DIV by zero.
  - rsp_err is 0 for all other ops.
- Disabled: no rsp_err port. DIV by zero goes to the ALU like any other op and its output is returned unchanged.

Decomposition:
- Package alu_arb_pkg: ALU select localparams (ALU_ADD ... ALU_NOP), the FSM state enum (IDLE, EXEC, RESP), and the DATA_W/SEL_W defaults.
- One sub-module, rr_arb2: 2-way round-robin grant.
  - Inputs: req[1:0], pointer, advance.
  - Outputs: grant[1:0].
  - The pointer register lives inside rr_arb2.

Test Plan:
- Reset then idle, no valid -> all outputs at reset values, alu_sel = 7, busy = 0, both ready low.
- req0 ADD x = 5, y = 7 with rsp_ready = 1 -> req0_ready for 1 cycle; rsp_valid 1 cycle later with rsp_r = 12, rsp_z = 0, rsp_id = 0.
- req0 and req1 valid together for 4 ops, sel = 1, x = y = 9, rsp_ready = 1 -> grants alternate 0, 1, 0, 1; each rsp_z = 1, rsp_r = 0.
- req1 MUL x = 6, y = 7, MULDIV_WAIT = 2 -> rsp_valid 2 cycles after accept, rsp_r = 42; alu_x, alu_y, alu_sel stable throughout EXEC.
- rsp_ready low for 5 cycles after a result -> rsp_valid and data held. A concurrent req0_valid sees ready low and is accepted the cycle after the handshake completes.
- With ALU_ARB_DIV0_TRAP_EN, DIV x = 10, y = 0 -> rsp_err = 1, rsp_r = 32'hFFFFFFFF, alu_sel never 6. Also assert rst_n low during a MUL EXEC -> no rsp_valid, and state is IDLE on release.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU sharing arbiter: ALU select codes, FSM states
// and default widths.
package alu_arb_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned SEL_W_DEF  = 3;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_SLT = 3'd4;
  localparam logic [2:0] ALU_MUL = 3'd5;
  localparam logic [2:0] ALU_DIV = 3'd6;
  localparam logic [2:0] ALU_NOP = 3'd7;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_share_arb_rr_arb2.sv
// Two-way round-robin grant; the priority pointer is held here and moves to
// the non-granted requester whenever a grant is taken.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] grant
);

  logic ptr;

  always_comb begin
    grant = '0;
    if (req == 2'b01)      grant = 2'b01;
    else if (req == 2'b10) grant = 2'b10;
    else if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= 1'b0;
    else if (advance) ptr <= grant[0];
  end

endmodule

// File: rtl/alu_share_arb.sv
// Shares one ALU between two requesters with round-robin arbitration and
// multicycle MUL/DIV waits. Define ALU_ARB_DIV0_TRAP_EN to add rsp_err and trap DIV by zero.
module alu_share_arb
  import alu_arb_pkg::*;
#(
  parameter int unsigned DATA_W      = DATA_W_DEF,
  parameter int unsigned SEL_W       = SEL_W_DEF,
  parameter int unsigned MULDIV_WAIT = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [DATA_W-1:0] req0_x,
  input  logic [DATA_W-1:0] req0_y,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [DATA_W-1:0] req1_x,
  input  logic [DATA_W-1:0] req1_y,
  input  logic [SEL_W-1:0]  req1_sel,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_r,
  output logic              rsp_z,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic [SEL_W-1:0]  alu_sel,
  input  logic [DATA_W-1:0] alu_r,
  input  logic              alu_z,
`ifdef ALU_ARB_DIV0_TRAP_EN
  output logic              busy,
  output logic              rsp_err
`else
  output logic              busy
`endif
);

  localparam int unsigned CNT_W = $clog2(MULDIV_WAIT) + 1;

  state_t            state, state_n;
  logic [CNT_W-1:0]  cnt;
  logic [1:0]        grant;
  logic              idle, xfer, gid, is_md, trap;
  logic [DATA_W-1:0] x_in, y_in;
  logic [SEL_W-1:0]  sel_in;

  assign idle = (state == IDLE);

  // Requests are masked outside IDLE so ready can only rise there.
  rr_arb2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     ({req1_valid, req0_valid} & {2{idle}}),
    .advance (xfer),
    .grant   (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];
  assign xfer       = |grant;
  assign gid        = grant[1];
  assign x_in       = gid ? req1_x   : req0_x;
  assign y_in       = gid ? req1_y   : req0_y;
  assign sel_in     = gid ? req1_sel : req0_sel;
  assign is_md      = (sel_in == SEL_W'(ALU_MUL)) || (sel_in == SEL_W'(ALU_DIV));
  assign busy       = !idle;

`ifdef ALU_ARB_DIV0_TRAP_EN
  assign trap = (sel_in == SEL_W'(ALU_DIV)) && (y_in == '0);
`else
  assign trap = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (xfer) state_n = trap ? RESP : EXEC;
      EXEC:    if (cnt == '0) state_n = RESP;
      RESP:    if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_x     <= '0;
      alu_y     <= '0;
      alu_sel   <= SEL_W'(ALU_NOP);
      rsp_valid <= 1'b0;
      rsp_id    <= 1'b0;
      rsp_r     <= '0;
      rsp_z     <= 1'b0;
      cnt       <= '0;
`ifdef ALU_ARB_DIV0_TRAP_EN
      rsp_err   <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: if (xfer) begin
          alu_x  <= x_in;
          alu_y  <= y_in;
          rsp_id <= gid;
          cnt    <= is_md ? CNT_W'(MULDIV_WAIT - 1) : '0;
          // A trapped divide answers immediately and keeps the ALU on NOP.
          if (trap) begin
            alu_sel   <= SEL_W'(ALU_NOP);
            rsp_r     <= '1;
            rsp_z     <= 1'b0;
            rsp_valid <= 1'b1;
`ifdef ALU_ARB_DIV0_TRAP_EN
            rsp_err   <= 1'b1;
`endif
          end else begin
            alu_sel <= sel_in;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_r     <= alu_r;
            rsp_z     <= alu_z;
            rsp_valid <= 1'b1;
`ifdef ALU_ARB_DIV0_TRAP_EN
            rsp_err   <= 1'b0;
`endif
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          alu_sel   <= SEL_W'(ALU_NOP);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: vector table plus scoreboard of
// expected responses, with hand sequences for arbitration, backpressure and reset.
module tb_alu_share_arb;
  import alu_arb_pkg::*;

  localparam int unsigned DW = 32;
  localparam int unsigned SW = 3;
  localparam int unsigned MW = 2;

  logic          clk, rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DW-1:0] req0_x, req0_y, req1_x, req1_y;
  logic [SW-1:0] req0_sel, req1_sel;
  logic          rsp_valid, rsp_ready, rsp_id, rsp_z, alu_z, busy;
  logic [DW-1:0] rsp_r, alu_x, alu_y, alu_r;
  logic [SW-1:0] alu_sel;
`ifdef ALU_ARB_DIV0_TRAP_EN
  logic          rsp_err;
`endif

  alu_share_arb #(.DATA_W(DW), .SEL_W(SW), .MULDIV_WAIT(MW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_x(req0_x), .req0_y(req0_y), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_x(req1_x), .req1_y(req1_y), .req1_sel(req1_sel),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_r(rsp_r), .rsp_z(rsp_z),
    .alu_x(alu_x), .alu_y(alu_y), .alu_sel(alu_sel), .alu_r(alu_r), .alu_z(alu_z),
`ifdef ALU_ARB_DIV0_TRAP_EN
    .busy(busy), .rsp_err(rsp_err)
`else
    .busy(busy)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU attached to the DUT's ALU port.
  always_comb begin
    alu_r = '0;
    case (alu_sel)
      ALU_ADD: alu_r = alu_x + alu_y;
      ALU_SUB: alu_r = alu_x - alu_y;
      ALU_AND: alu_r = alu_x & alu_y;
      ALU_OR:  alu_r = alu_x | alu_y;
      ALU_SLT: alu_r = {31'b0, $signed(alu_x) < $signed(alu_y)};
      ALU_MUL: alu_r = alu_x * alu_y;
      ALU_DIV: alu_r = (alu_y == '0) ? '1 : alu_x / alu_y;
      default: alu_r = '0;
    endcase
    alu_z = (alu_r == '0);
  end

  typedef struct {
    logic          id;
    logic [2:0]    sel;
    logic [31:0]   x, y, r;
    logic          z, err;
    logic [2:0]    asel;
    int unsigned   lat;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] r;
    logic        z, err;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  vec_t vt[11];
  int   checks = 0;
  int   errors = 0;
  logic div0_seen = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rsp_unexpected actual id=%0d r=%0h expected no response", rsp_id, rsp_r);
      end else begin
        mon_e = sbq.pop_front();
        chk("rsp_id", 32'(rsp_id), 32'(mon_e.id));
        chk("rsp_r", rsp_r, mon_e.r);
        chk("rsp_z", 32'(rsp_z), 32'(mon_e.z));
`ifdef ALU_ARB_DIV0_TRAP_EN
        chk("rsp_err", 32'(rsp_err), 32'(mon_e.err));
`endif
      end
    end
  end

  always @(negedge clk)
    if (rst_n && alu_sel == ALU_DIV && alu_y == '0) div0_seen = 1'b1;

  task automatic drive(input logic id, input logic [2:0] sel, input logic [31:0] x, input logic [31:0] y);
    if (id) begin req1_valid = 1'b1; req1_sel = sel; req1_x = x; req1_y = y; end
    else    begin req0_valid = 1'b1; req0_sel = sel; req0_x = x; req0_y = y; end
  endtask

  task automatic wait_acc(input logic id, output logic ok);
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (id ? req1_ready : req0_ready) begin ok = 1'b1; break; end
    end
    chk("accept", 32'(ok), 32'd1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    sbq.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic drain();
    for (int n = 0; n < 30 && (sbq.size() != 0 || busy); n++) @(posedge clk);
    #1;
    chk("drain_queue", 32'(sbq.size()), 32'd0);
  endtask

  task automatic issue(input vec_t v);
    logic ok;
    int unsigned lat;
    drive(v.id, v.sel, v.x, v.y);
    wait_acc(v.id, ok);
    if (ok) sbq.push_back('{v.id, v.r, v.z, v.err});
    @(posedge clk);
    #1;
    if (v.id) req1_valid = 1'b0; else req0_valid = 1'b0;
    if (!ok) return;
    lat = 0;
    forever begin
      @(negedge clk);
      chk("alu_sel_hold", 32'(alu_sel), 32'(v.asel));
      chk("alu_x_hold", alu_x, v.x);
      if (rsp_valid || lat >= 10) break;
      @(posedge clk);
      lat++;
    end
    chk("latency", lat, v.lat);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic ok, got;
    logic [31:0] held;
    req0_x = '0; req0_y = '0; req0_sel = '0; req1_x = '0; req1_y = '0; req1_sel = '0;
    vt[0]  = '{1'b0, ALU_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1'b0, ALU_ADD, 1};
    vt[1]  = '{1'b1, ALU_SUB, 32'd9, 32'd9, 32'd0, 1'b1, 1'b0, ALU_SUB, 1};
    vt[2]  = '{1'b0, ALU_AND, 32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 1'b0, 1'b0, ALU_AND, 1};
    vt[3]  = '{1'b1, ALU_OR, 32'h000000F0, 32'h00000F00, 32'h00000FF0, 1'b0, 1'b0, ALU_OR, 1};
    vt[4]  = '{1'b0, ALU_SLT, 32'hFFFFFFFF, 32'd1, 32'd1, 1'b0, 1'b0, ALU_SLT, 1};
    vt[5]  = '{1'b1, ALU_SLT, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b1, 1'b0, ALU_SLT, 1};
    vt[6]  = '{1'b1, ALU_MUL, 32'd6, 32'd7, 32'd42, 1'b0, 1'b0, ALU_MUL, 2};
    vt[7]  = '{1'b0, ALU_DIV, 32'd100, 32'd7, 32'd14, 1'b0, 1'b0, ALU_DIV, 2};
    vt[8]  = '{1'b0, ALU_NOP, 32'd3, 32'd4, 32'd0, 1'b1, 1'b0, ALU_NOP, 1};
`ifdef ALU_ARB_DIV0_TRAP_EN
    vt[9]  = '{1'b1, ALU_DIV, 32'd10, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b1, ALU_NOP, 0};
`else
    vt[9]  = '{1'b1, ALU_DIV, 32'd10, 32'd0, 32'hFFFFFFFF, 1'b0, 1'b0, ALU_DIV, 2};
`endif
    vt[10] = '{1'b1, ALU_MUL, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE, 1'b0, 1'b0, ALU_MUL, 2};

    do_reset();
    @(negedge clk);
    chk("rst_alu_sel", 32'(alu_sel), 32'd7);
    chk("rst_alu_x", alu_x, 32'd0);
    chk("rst_alu_y", alu_y, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ready", 32'({req0_ready, req1_ready}), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_r", rsp_r, 32'd0);
    chk("rst_rsp_id_z", 32'({rsp_id, rsp_z}), 32'd0);
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) issue(vt[i]);
    drain();
`ifdef ALU_ARB_DIV0_TRAP_EN
    chk("div0_alu_sel_never_6", 32'(div0_seen), 32'd0);
`endif

    // Both requesters contend: grants must alternate starting at 0.
    do_reset();
    drive(1'b0, ALU_SUB, 32'd9, 32'd9);
    drive(1'b1, ALU_SUB, 32'd9, 32'd9);
    for (int k = 0; k < 4; k++) begin
      ok = 1'b0;
      got = 1'b0;
      for (int n = 0; n < 20; n++) begin
        @(negedge clk);
        if (req0_ready || req1_ready) begin ok = 1'b1; got = req1_ready; break; end
      end
      chk("rr_accept", 32'(ok), 32'd1);
      chk("rr_one_hot", 32'(req0_ready & req1_ready), 32'd0);
      chk("rr_grant", 32'(got), 32'(k % 2));
      if (ok) sbq.push_back('{got, 32'd0, 1'b1, 1'b0});
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    drain();

    // Backpressure: response held, pending req0 waits until after the handshake.
    rsp_ready = 1'b0;
    drive(1'b1, ALU_ADD, 32'd20, 32'd22);
    wait_acc(1'b1, ok);
    if (ok) sbq.push_back('{1'b1, 32'd42, 1'b0, 1'b0});
    @(posedge clk);
    #1 req1_valid = 1'b0;
    for (int n = 0; n < 10 && !rsp_valid; n++) @(negedge clk);
    held = rsp_r;
    chk("bp_valid", 32'(rsp_valid), 32'd1);
    drive(1'b0, ALU_OR, 32'd1, 32'd2);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_r", rsp_r, 32'd42);
      chk("bp_hold_id", 32'(rsp_id), 32'd1);
      chk("bp_ready_low", 32'(req0_ready), 32'd0);
      @(posedge clk);
      #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp_ready_during_hs", 32'(req0_ready), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("bp_ready_after_hs", 32'(req0_ready), 32'd1);
    if (req0_ready) sbq.push_back('{1'b0, 32'd3, 1'b0, 1'b0});
    @(posedge clk);
    #1 req0_valid = 1'b0;
    drain();

    // Reset during a MUL in EXEC aborts it with no response.
    drive(1'b1, ALU_MUL, 32'd6, 32'd7);
    wait_acc(1'b1, ok);
    @(posedge clk);
    #1 req1_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_alu_sel", 32'(alu_sel), 32'd7);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      chk("abort_no_rsp", 32'(rsp_valid), 32'd0);
      chk("abort_idle", 32'(busy), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
